// File: rtl/rv32i_dmem.sv
// RV32I data memory: B/H/W loads and stores with little-endian byte lanes and one-cycle response.
// Define RV32I_DMEM_MISALIGN_SPLIT_EN to split misaligned accesses over two words (latency 2).
module rv32i_dmem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W:0] DEPTH_L = (WIDX_W + 1)'(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] res;
    res = 32'h0;
    case (f3)
      3'b000:  res = {{24{d[7]}}, d[7:0]};
      3'b001:  res = {{16{d[15]}}, d[15:0]};
      3'b010:  res = d;
      3'b100:  res = {24'h0, d[7:0]};
      3'b101:  res = {16'h0, d[15:0]};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  logic [WIDX_W-1:0] w_word;
  logic [WIDX_W:0]   w_word_ext;
  logic [WIDX_W:0]   w_word_nxt;
  logic [1:0]        w_off;
  logic [4:0]        w_shamt;
  logic [3:0]        w_size_be;
  logic              w_bad_f3;
  logic              w_misalign;
  logic              w_oob;
  logic              w_err;
  logic              w_accept;
  logic [7:0]        w_be8;
  logic [63:0]       w_wdata64;
  logic [31:0]       w_rd_lo;

  logic              w_mem_we;
  logic [MEM_AW-1:0] w_mem_idx;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;

  logic              w_rsp_valid;
  logic              w_rsp_err;
  logic [31:0]       w_rsp_rdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  assign w_word     = req_addr_i[ADDR_W-1:2];
  assign w_off      = req_addr_i[1:0];
  assign w_shamt    = {w_off, 3'b000};
  assign w_word_ext = {1'b0, w_word};
  assign w_word_nxt = w_word_ext + {{WIDX_W{1'b0}}, 1'b1};
  assign w_accept   = req_valid_i && req_ready_o;
  // Lanes for words w and w+1; the upper half only matters for a split access.
  assign w_be8      = {4'h0, w_size_be} << w_off;
  assign w_wdata64  = {32'h0, req_wdata_i} << w_shamt;
  assign w_rd_lo    = (w_word_ext < DEPTH_L) ? r_mem[w_word[MEM_AW-1:0]] : 32'h0;

  always_comb begin
    w_size_be = 4'h0;
    w_bad_f3  = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b100: w_size_be = 4'b0001;
      3'b001, 3'b101: w_size_be = 4'b0011;
      3'b010:         w_size_be = 4'b1111;
      default:        w_bad_f3  = 1'b1;
    endcase
    w_misalign = ((w_size_be == 4'b0011) && (w_off == 2'd3)) ||
                 ((w_size_be == 4'b1111) && (w_off != 2'd0));
    w_oob = (w_word_ext >= DEPTH_L) || (w_misalign && (w_word_nxt >= DEPTH_L));
    w_err = w_bad_f3 || (req_we_i && req_funct3_i[2]) || w_oob;
`ifndef RV32I_DMEM_MISALIGN_SPLIT_EN
    w_err = w_err || w_misalign;
`endif
  end

`ifdef RV32I_DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {StIdle, StSplit} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [MEM_AW-1:0] r_hi_idx;
  logic [3:0]        r_hi_be;
  logic [31:0]       r_hi_wdata;
  logic [31:0]       r_lo_rdata;
  logic [31:0]       w_split_rd;

  assign req_ready_o = rst && (r_state == StIdle);
  assign w_split_rd  = 32'({r_mem[r_hi_idx], r_lo_rdata} >> {r_off, 3'b000});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_f3       <= 3'b000;
      r_off      <= 2'd0;
      r_hi_idx   <= '0;
      r_hi_be    <= 4'h0;
      r_hi_wdata <= 32'h0;
      r_lo_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_misalign && !w_err) begin
        r_we       <= req_we_i;
        r_f3       <= req_funct3_i;
        r_off      <= w_off;
        r_hi_idx   <= w_word_nxt[MEM_AW-1:0];
        r_hi_be    <= w_be8[7:4];
        r_hi_wdata <= w_wdata64[63:32];
        r_lo_rdata <= w_rd_lo;
      end
    end
  end
`else
  logic w_unused;

  assign req_ready_o = rst;
  assign w_unused    = ^{w_be8[7:4], w_wdata64[63:32]};
`endif

  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = 32'h0;
    w_mem_we    = 1'b0;
    w_mem_idx   = w_word[MEM_AW-1:0];
    w_mem_be    = w_be8[3:0];
    w_mem_wdata = w_wdata64[31:0];
`ifdef RV32I_DMEM_MISALIGN_SPLIT_EN
    w_state_nxt = r_state;
    if (r_state == StSplit) begin
      w_state_nxt = StIdle;
      w_rsp_valid = 1'b1;
      w_mem_we    = r_we;
      w_mem_idx   = r_hi_idx;
      w_mem_be    = r_hi_be;
      w_mem_wdata = r_hi_wdata;
      if (!r_we) begin
        w_rsp_rdata = f_extend(r_f3, w_split_rd);
      end
    end else
`endif
    if (w_accept) begin
      if (w_err) begin
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
      end
`ifdef RV32I_DMEM_MISALIGN_SPLIT_EN
      else if (w_misalign) begin
        w_state_nxt = StSplit;
        w_mem_we    = req_we_i;
      end
`endif
      else begin
        w_rsp_valid = 1'b1;
        w_mem_we    = req_we_i;
        if (!req_we_i) begin
          w_rsp_rdata = f_extend(req_funct3_i, w_rd_lo >> w_shamt);
        end
      end
    end
  end

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_rv32i_dmem.sv
// Scoreboard bench for rv32i_dmem: directed requests push expected responses, a monitor checks them.
`timescale 1ns/1ps
module tb_rv32i_dmem;

  localparam int unsigned DEPTH = 256;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  always #5 clk = ~clk;

  rv32i_dmem #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {31'h0, rsp_valid_o}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.d);
        chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.e});
        chk("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_rdata", rsp_rdata_o, 32'h0);
      chk("idle_err", {31'h0, rsp_err_o}, 32'h0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_rsp", {31'h0, rsp_valid_o}, 32'h1);
        void'(sb.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                       input int lat);
    exp_t e;
    int   n;
    n = 0;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("ready_timeout", {31'h0, req_ready_o}, 32'h1);
    end else begin
      e.d   = exp_d;
      e.e   = exp_e;
      e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, req_ready_o}, 32'h0);
    chk("reset_valid", {31'h0, rsp_valid_o}, 32'h0);
    rst = 1'b1;
    #1 chk("ready_after_reset", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);

    issue(1'b1, F_W, 32'h00, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b1, F_W, 32'h04, 32'h0, 32'h0, 1'b0, 1);
    // Store then immediate load of the same word.
    issue(1'b1, F_W, 32'h10, 32'h87654321, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, 32'h10, 32'h0, 32'h87654321, 1'b0, 1);
    // Byte store and signed/unsigned sub-word loads.
    issue(1'b1, F_W, 32'h10, 32'h00210000, 32'h0, 1'b0, 1);
    issue(1'b1, F_B, 32'h13, 32'h80, 32'h0, 1'b0, 1);
    issue(1'b0, F_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    issue(1'b0, F_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 1);
    issue(1'b0, F_HU, 32'h12, 32'h0, 32'h00008021, 1'b0, 1);
    // Halfword lane placement; upper wdata bits must be ignored.
    issue(1'b1, F_W, 32'h20, 32'h11111111, 32'h0, 1'b0, 1);
    issue(1'b1, F_H, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, 32'h20, 32'h0, 32'hBEEF1111, 1'b0, 1);
    issue(1'b0, F_H, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
    issue(1'b0, F_B, 32'h21, 32'h0, 32'h00000011, 1'b0, 1);
    // Range boundary.
    issue(1'b1, F_W, 32'h00, 32'h11223344, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, DEPTH * 4, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, F_W, DEPTH * 4, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h00, 32'h0, 32'h11223344, 1'b0, 1);
    issue(1'b1, F_W, DEPTH * 4 - 4, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, DEPTH * 4 - 4, 32'h0, 32'hCAFEF00D, 1'b0, 1);
    issue(1'b0, F_W, DEPTH * 4 - 3, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, F_HU, DEPTH * 4 - 1, 32'h0, 32'h0, 1'b1, 1);
    // Illegal funct3 codes and unsigned store sizes.
    issue(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b110, 32'h00, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b111, 32'h00, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, F_BU, 32'h10, 32'hFF, 32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h10, 32'h0, 32'h80210000, 1'b0, 1);
    // Misaligned word store across words 0 and 1.
    issue(1'b1, F_W, 32'h00, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b1, F_W, 32'h04, 32'h0, 32'h0, 1'b0, 1);
`ifdef RV32I_DMEM_MISALIGN_SPLIT_EN
    issue(1'b1, F_W, 32'h01, 32'hAABBCCDD, 32'h0, 1'b0, 2);
    chk("split_ready_low", {31'h0, req_ready_o}, 32'h0);
    issue(1'b0, F_W, 32'h00, 32'h0, 32'hBBCCDD00, 1'b0, 1);
    issue(1'b0, F_W, 32'h04, 32'h0, 32'h000000AA, 1'b0, 1);
    issue(1'b0, F_W, 32'h01, 32'h0, 32'hAABBCCDD, 1'b0, 2);
    issue(1'b0, F_H, 32'h03, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    // Reset in the middle of a split store drops the second half and the response.
    issue(1'b1, F_W, 32'h30, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b1, F_W, 32'h34, 32'h0, 32'h0, 1'b0, 1);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = F_W;
    req_addr_i   = 32'h32;
    req_wdata_i  = 32'h11223344;
    chk("pre_split_ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("in_split_ready", {31'h0, req_ready_o}, 32'h0);
    rst = 1'b0;
    #1 chk("rst_ready", {31'h0, req_ready_o}, 32'h0);
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_release_ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    issue(1'b0, F_W, 32'h30, 32'h0, 32'h33440000, 1'b0, 1);
    issue(1'b0, F_W, 32'h34, 32'h0, 32'h00000000, 1'b0, 1);
`else
    issue(1'b1, F_W, 32'h01, 32'hAABBCCDD, 32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h00, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, 32'h04, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b0, F_W, 32'h02, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, F_H, 32'h03, 32'h0, 32'h0, 1'b1, 1);
    rst = 1'b0;
    #1 chk("rst_ready", {31'h0, req_ready_o}, 32'h0);
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_release_ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    issue(1'b0, F_W, 32'h10, 32'h0, 32'h80210000, 1'b0, 1);
`endif
    // Back-to-back traffic: eight stores then eight loads, one per cycle.
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, F_W, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i * 17), 32'h0, 1'b0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", {31'h0, req_ready_o}, 32'h1);
      issue(1'b0, F_W, 32'h40 + 32'(4 * i), 32'h0, 32'hA0000000 + 32'(i * 17), 1'b0, 1);
    end
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
